// File: rtl/bus_pkg.sv
// Shared definitions for the shared-bus controller: widths, slave-index field,
// controller state encoding and small decode helpers.
package bus_pkg;

  localparam int BUS_ADDR_W   = 30;
  localparam int BUS_DATA_W   = 32;
  localparam int BUS_N_MASTER = 4;
  localparam int BUS_N_SLAVE  = 8;
  localparam int BUS_SIDX_HI  = 29;
  localparam int BUS_SIDX_LO  = 27;
  localparam int BUS_SIDX_W   = 3;
  localparam int BUS_WDOG_W   = 8;
  localparam int BUS_TIMEOUT  = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCESS = 2'd2
  } bus_state_e;

  // One-hot slave select from a slave index.
  function automatic logic [BUS_N_SLAVE-1:0] slave_onehot(input logic [BUS_SIDX_W-1:0] idx);
    slave_onehot = {{(BUS_N_SLAVE-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Binary index of a one-hot master grant (zero when no grant).
  function automatic logic [1:0] master_index(input logic [BUS_N_MASTER-1:0] oh);
    case (oh)
      4'b0001: master_index = 2'd0;
      4'b0010: master_index = 2'd1;
      4'b0100: master_index = 2'd2;
      4'b1000: master_index = 2'd3;
      default: master_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Four-way round-robin arbiter: picks the first requester at or above the
// pointer (wrapping) and returns it as a one-hot grant.
module bus_arbiter
  import bus_pkg::*;
(
  input  logic [BUS_N_MASTER-1:0] req,
  input  logic [1:0]              ptr,
  output logic [BUS_N_MASTER-1:0] grant
);

  logic       found_s;
  logic [1:0] idx_s;

  // Search upward from the pointer and grant the first active request.
  always_comb begin
    grant   = {BUS_N_MASTER{1'b0}};
    found_s = 1'b0;
    idx_s   = 2'd0;
    for (int i = 0; i < BUS_N_MASTER; i++) begin
      idx_s = ptr + 2'(i);
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// Shared-bus controller: round-robin master arbitration, slave decode on the
// address slave-index field, master/slave muxing and a watchdog that completes
// an unanswered access with bus_err so no master can hang.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W   = BUS_ADDR_W,
  parameter int DATA_W   = BUS_DATA_W,
  parameter int N_MASTER = BUS_N_MASTER,
  parameter int TIMEOUT  = BUS_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTER-1:0]          m_req,
  input  logic [N_MASTER-1:0]          m_as,
  input  logic [N_MASTER-1:0]          m_rw,
  input  logic [N_MASTER*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTER*DATA_W-1:0]   m_wr_data,
  output logic [N_MASTER-1:0]          m_grnt,
  output logic                         m_rdy,
  output logic [DATA_W-1:0]            m_rd_data,
  output logic                         bus_err,
  output logic [BUS_N_SLAVE-1:0]       s_cs,
  output logic                         s_as,
  output logic                         s_rw,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wr_data,
  input  logic [BUS_N_SLAVE*DATA_W-1:0] s_rd_data,
  input  logic [BUS_N_SLAVE-1:0]       s_rdy
);

  bus_state_e              state_q, state_d;
  logic [N_MASTER-1:0]     grnt_q, grnt_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [BUS_WDOG_W-1:0]   wdog_q, wdog_d;
  logic [BUS_SIDX_W-1:0]   sel_q, sel_d;

  logic [N_MASTER-1:0]     arb_grant_s;
  logic                    has_grnt_s;
  logic [1:0]              owner_s;
  logic                    owner_req_s;
  logic                    owner_as_s;
  logic                    owner_rw_s;
  logic [ADDR_W-1:0]       owner_addr_s;
  logic [DATA_W-1:0]       owner_wr_data_s;
  logic                    sel_rdy_s;
  logic [DATA_W-1:0]       sel_rd_data_s;
  logic                    timeout_s;

  bus_arbiter u_arbiter (
    .req   (m_req),
    .ptr   (rr_ptr_q),
    .grant (arb_grant_s)
  );

  assign m_grnt          = grnt_q;
  assign has_grnt_s      = |grnt_q;
  assign owner_s         = master_index(grnt_q);
  assign owner_req_s     = |(m_req & grnt_q);
  assign owner_as_s      = |(m_as & grnt_q);
  assign owner_rw_s      = |(m_rw & grnt_q);
  assign owner_addr_s    = m_addr[owner_s*ADDR_W +: ADDR_W];
  assign owner_wr_data_s = m_wr_data[owner_s*DATA_W +: DATA_W];
  assign sel_rdy_s       = s_rdy[sel_q];
  assign sel_rd_data_s   = s_rd_data[sel_q*DATA_W +: DATA_W];
  // Watchdog counts ACCESS cycles from zero, so TIMEOUT-1 marks the TIMEOUT-th one.
  assign timeout_s       = (wdog_q == BUS_WDOG_W'(TIMEOUT - 1));

  // State, grant, pointer, watchdog and latched slave index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grnt_q   <= {N_MASTER{1'b0}};
      rr_ptr_q <= 2'd0;
      wdog_q   <= {BUS_WDOG_W{1'b0}};
      sel_q    <= {BUS_SIDX_W{1'b0}};
    end else begin
      state_q  <= state_d;
      grnt_q   <= grnt_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
      sel_q    <= sel_d;
    end
  end

  // Next-state: arbitration in IDLE, strobe/abandon/release in GRANT,
  // completion or watchdog expiry in ACCESS.
  always_comb begin
    state_d  = state_q;
    grnt_d   = grnt_q;
    rr_ptr_d = rr_ptr_q;
    wdog_d   = wdog_q;
    sel_d    = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (|m_req) begin
          grnt_d  = arb_grant_s;
          state_d = ST_GRANT;
        end else begin
          grnt_d  = {N_MASTER{1'b0}};
        end
      end
      ST_GRANT: begin
        if (!owner_req_s) begin
          // Owner released (or abandoned): the next search starts past it.
          grnt_d   = {N_MASTER{1'b0}};
          rr_ptr_d = owner_s + 2'd1;
          state_d  = ST_IDLE;
        end else if (owner_as_s) begin
          sel_d   = owner_addr_s[BUS_SIDX_HI:BUS_SIDX_LO];
          wdog_d  = {BUS_WDOG_W{1'b0}};
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_GRANT;
        end
      end
      ST_ACCESS: begin
        if (sel_rdy_s || timeout_s) begin
          wdog_d  = {BUS_WDOG_W{1'b0}};
          state_d = ST_GRANT;
        end else begin
          wdog_d  = wdog_q + {{(BUS_WDOG_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        grnt_d  = {N_MASTER{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: owner signals forwarded to the slaves, slave select, and the
  // response mux; a real s_rdy always takes precedence over the watchdog.
  always_comb begin
    m_rdy     = 1'b0;
    m_rd_data = {DATA_W{1'b0}};
    bus_err   = 1'b0;
    s_cs      = {BUS_N_SLAVE{1'b0}};
    s_as      = 1'b0;
    s_rw      = 1'b0;
    s_addr    = {ADDR_W{1'b0}};
    s_wr_data = {DATA_W{1'b0}};
    if (has_grnt_s) begin
      s_as      = owner_as_s;
      s_rw      = owner_rw_s;
      s_addr    = owner_addr_s;
      s_wr_data = owner_wr_data_s;
    end else begin
      s_as      = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        s_cs = {BUS_N_SLAVE{1'b0}};
      end
      ST_GRANT: begin
        // Live decode so a combinational slave sees cs together with as.
        s_cs = slave_onehot(owner_addr_s[BUS_SIDX_HI:BUS_SIDX_LO]);
      end
      ST_ACCESS: begin
        s_cs = slave_onehot(sel_q);
        if (sel_rdy_s) begin
          m_rdy     = 1'b1;
          m_rd_data = owner_rw_s ? {DATA_W{1'b0}} : sel_rd_data_s;
        end else if (timeout_s) begin
          m_rdy   = 1'b1;
          bus_err = 1'b1;
        end else begin
          m_rdy   = 1'b0;
        end
      end
      default: begin
        s_cs = {BUS_N_SLAVE{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: directed scenarios followed by randomized
// transactions, all checked against a transaction-level reference model.
module tb_bus_ctrl;

  localparam int TO = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   m_req, m_as, m_rw;
  logic [119:0] m_addr;
  logic [127:0] m_wr_data;
  logic [3:0]   m_grnt;
  logic         m_rdy;
  logic [31:0]  m_rd_data;
  logic         bus_err;
  logic [7:0]   s_cs;
  logic         s_as;
  logic         s_rw;
  logic [29:0]  s_addr;
  logic [31:0]  s_wr_data;
  logic [255:0] s_rd_data;
  logic [7:0]   s_rdy;

  int ncmp = 0;
  int nerr = 0;
  int model_ptr = 0;

  bus_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_as(m_as), .m_rw(m_rw), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_grnt(m_grnt), .m_rdy(m_rdy), .m_rd_data(m_rd_data), .bus_err(bus_err),
    .s_cs(s_cs), .s_as(s_as), .s_rw(s_rw), .s_addr(s_addr), .s_wr_data(s_wr_data),
    .s_rd_data(s_rd_data), .s_rdy(s_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester at or after the pointer, mod 4.
  function automatic int pick(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (mask[(model_ptr + i) % 4]) return (model_ptr + i) % 4;
    end
    return 0;
  endfunction

  // One ownership period: idle cycle, grant, n_acc accesses, release.
  task automatic run_txn(input logic [3:0] mask, input logic [29:0] addr, input logic rw,
                         input int lat, input logic [31:0] rdata, input bit noise_all,
                         input int n_acc);
    int own;
    logic [2:0] idx;
    logic [31:0] wd;
    logic [3:0] nz_as;
    logic [7:0] nz_rdy;
    bit exp_rdy, exp_err;
    logic [31:0] exp_data;
    m_req = mask; m_as = 4'($urandom); s_rdy = 8'($urandom);
    #1;
    chk("idle_grnt", m_grnt, 4'h0);
    chk("idle_s_as", s_as, 1'b0);
    chk("idle_s_cs", s_cs, 8'h00);
    own = pick(mask);
    m_as = 4'h0; s_rdy = 8'h00;
    tick();
    chk("grant", m_grnt, 4'b1 << own);
    for (int a = 0; a < n_acc; a++) begin
      idx = addr[29:27];
      wd = $urandom;
      m_addr[own*30 +: 30] = addr;
      m_rw[own] = rw;
      m_wr_data[own*32 +: 32] = wd;
      nz_as = noise_all ? 4'hF : 4'($urandom);
      m_as = nz_as | (4'b1 << own);
      #1;
      chk("strobe_s_as", s_as, 1'b1);
      chk("strobe_s_cs", s_cs, 8'b1 << idx);
      chk("strobe_s_addr", s_addr, addr);
      chk("strobe_s_rw", s_rw, rw);
      chk("strobe_s_wr_data", s_wr_data, wd);
      chk("strobe_m_rdy", m_rdy, 1'b0);
      tick();
      for (int k = 1; k <= TO; k++) begin
        nz_as = noise_all ? 4'hF : 4'($urandom);
        m_as = nz_as & ~(4'b1 << own);
        nz_rdy = noise_all ? 8'hFF : 8'($urandom);
        s_rdy = (nz_rdy & ~(8'b1 << idx)) | ((k == lat) ? (8'b1 << idx) : 8'h00);
        for (int j = 0; j < 8; j++) s_rd_data[j*32 +: 32] = $urandom;
        s_rd_data[idx*32 +: 32] = rdata;
        #1;
        exp_rdy  = (k == lat) || (k == TO);
        exp_err  = (k == TO) && (k != lat);
        exp_data = ((k == lat) && !rw) ? rdata : 32'h0;
        chk("acc_m_rdy", m_rdy, exp_rdy);
        chk("acc_bus_err", bus_err, exp_err);
        chk("acc_m_rd_data", m_rd_data, exp_data);
        chk("acc_s_cs", s_cs, 8'b1 << idx);
        chk("acc_s_as", s_as, 1'b0);
        tick();
        if (exp_rdy) break;
      end
      s_rdy = 8'h00; m_as = 4'h0;
      addr = 30'($urandom);
    end
    m_req = mask & ~(4'b1 << own);
    #1;
    chk("hold_grnt", m_grnt, 4'b1 << own);
    chk("hold_m_rdy", m_rdy, 1'b0);
    tick();
    model_ptr = (own + 1) % 4;
  endtask

  initial begin
    int own;
    rst = 1'b1; m_req = 4'hF; m_as = 4'h0; m_rw = 4'h0;
    m_addr = '0; m_wr_data = '0; s_rd_data = '0; s_rdy = 8'h00;

    // Reset with every master requesting.
    tick(); tick();
    chk("rst_grnt", m_grnt, 4'h0);
    chk("rst_m_rdy", m_rdy, 1'b0);
    chk("rst_s_cs", s_cs, 8'h00);
    chk("rst_s_addr", s_addr, 30'h0);
    chk("rst_m_rd_data", m_rd_data, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_grnt", m_grnt, 4'b0001);
    rst = 1'b1; m_req = 4'h0;
    tick();
    chk("rst2_grnt", m_grnt, 4'h0);
    rst = 1'b0; model_ptr = 0;

    // Round robin: all request, each does one write and drops.
    for (int i = 0; i < 5; i++) run_txn(4'hF, 30'($urandom), 1'b1, 2, 32'h0, 1'b0, 1);

    // Read from slave 2 by master 2, ready three cycles into the access.
    run_txn(4'b0100, 30'h1000_0004, 1'b0, 3, 32'hDEADBEEF, 1'b0, 1);

    // Watchdog expiry on slave 7, then ready on the last allowed cycle.
    run_txn(4'b0001, 30'h3800_0000, 1'b0, 100, 32'h1234_5678, 1'b0, 1);
    run_txn(4'b0001, 30'h3800_0000, 1'b0, TO, 32'hCAFE_F00D, 1'b0, 1);

    // Isolation: every non-owner strobes and every other slave is ready.
    run_txn(4'b0001, 30'h1800_0000, 1'b0, 4, 32'hA5A5_5A5A, 1'b1, 1);

    // Abandon in GRANT without strobing.
    m_req = 4'b0010; m_as = 4'h0;
    own = pick(m_req);
    tick();
    chk("abandon_grant", m_grnt, 4'b1 << own);
    m_req = 4'h0;
    #1;
    chk("abandon_s_as", s_as, 1'b0);
    tick();
    chk("abandon_grnt", m_grnt, 4'h0);
    chk("abandon_s_as2", s_as, 1'b0);
    model_ptr = (own + 1) % 4;

    // Reset during ACCESS; a late ready must not complete anything.
    m_req = 4'b0100;
    own = pick(m_req);
    tick();
    chk("rstacc_grant", m_grnt, 4'b1 << own);
    m_addr[own*30 +: 30] = 30'h2000_0000;
    m_rw[own] = 1'b0;
    m_as = 4'b1 << own;
    tick();
    m_as = 4'h0; rst = 1'b1;
    tick();
    rst = 1'b0; m_req = 4'h0;
    #1;
    chk("rstacc_grnt", m_grnt, 4'h0);
    s_rdy = 8'hFF;
    #1;
    chk("rstacc_m_rdy", m_rdy, 1'b0);
    chk("rstacc_bus_err", bus_err, 1'b0);
    tick();
    chk("rstacc_m_rdy2", m_rdy, 1'b0);
    chk("rstacc_grnt2", m_grnt, 4'h0);
    s_rdy = 8'h00;
    model_ptr = 0;

    // Randomized ownership periods.
    for (int t = 0; t < 40; t++) begin
      run_txn(4'($urandom_range(1, 15)), 30'($urandom), 1'($urandom),
              $urandom_range(1, 10), $urandom, 1'b0, $urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
